// File: rtl/mmu_sfr_write_unit.sv
`default_nettype none
// ============================================================================
// mmu_sfr_write_unit : queued SFR write unit (SET / half-field / RES), in-order
// commit. Optional read-back port enabled by MMU_SFR_WR_READBACK_EN. Rev 1.0
// ============================================================================
module mmu_sfr_write_unit #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 64,
  parameter int IDX_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_wr_reg_en,
  input  logic [1:0]        cpu_wr_reg_cmd,
  input  logic [IDX_W-1:0]  cpu_wr_reg_idx,
  input  logic [DATA_W-1:0] cpu_wr_reg_val,
  output logic              cpu_wr_reg_rdy,
  output logic              upd_valid,
  output logic [IDX_W-1:0]  upd_idx,
  output logic [DATA_W-1:0] upd_val,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_val,
  output logic              err,
  input  logic              err_clr,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SFR_AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] CMD_SET  = 2'b00;
  localparam logic [1:0] CMD_HFXB = 2'b01;
  localparam logic [1:0] CMD_HFXT = 2'b10;
  localparam logic [1:0] CMD_RES  = 2'b11;

  localparam logic [IDX_W:0]   NUM_REGS_LIM = (IDX_W + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(FIFO_DEPTH);

  // Write queue storage
  logic [1:0]        r_q_cmd [FIFO_DEPTH];
  logic [IDX_W-1:0]  r_q_idx [FIFO_DEPTH];
  logic [DATA_W-1:0] r_q_val [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [DATA_W-1:0] r_sfr [NUM_REGS];

  logic              r_upd_valid;
  logic [IDX_W-1:0]  r_upd_idx;
  logic [DATA_W-1:0] r_upd_val;
  logic              r_err;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [1:0]        w_head_cmd;
  logic [IDX_W-1:0]  w_head_idx;
  logic [DATA_W-1:0] w_head_val;
  logic              w_idx_ok;
  logic              w_cmd_ok;
  logic              w_commit;
  logic              w_error;
  logic [SFR_AW-1:0] w_sfr_addr;
  logic [DATA_W-1:0] w_old;
  logic [HALF_W-1:0] w_mask;
  logic [HALF_W-1:0] w_data;
  logic [DATA_W-1:0] w_new;

  assign w_full         = (r_count == DEPTH_CNT);
  assign cpu_wr_reg_rdy = !w_full;
  assign w_push         = cpu_wr_reg_en && !w_full;
  assign w_pop          = (r_count != '0);
  assign busy           = (r_count != '0);

  assign w_head_cmd = r_q_cmd[r_rd_ptr];
  assign w_head_idx = r_q_idx[r_rd_ptr];
  assign w_head_val = r_q_val[r_rd_ptr];

  assign w_idx_ok   = ({1'b0, w_head_idx} < NUM_REGS_LIM);
  assign w_cmd_ok   = (w_head_cmd != CMD_RES);
  assign w_commit   = w_pop && w_idx_ok && w_cmd_ok;
  assign w_error    = w_pop && !(w_idx_ok && w_cmd_ok);

  // Old value is read straight from the SFR array, so a commit always sees
  // the result of the commit on the previous edge.
  assign w_sfr_addr = w_head_idx[SFR_AW-1:0];
  assign w_old      = r_sfr[w_sfr_addr];
  assign w_mask     = w_head_val[DATA_W-1:HALF_W];
  assign w_data     = w_head_val[HALF_W-1:0];

  always_comb begin
    w_new = w_head_val;
    case (w_head_cmd)
      CMD_SET:  w_new = w_head_val;
      CMD_HFXB: w_new = {w_old[DATA_W-1:HALF_W],
                         (w_old[HALF_W-1:0] & ~w_mask) | (w_data & w_mask)};
      CMD_HFXT: w_new = {(w_old[DATA_W-1:HALF_W] & ~w_mask) | (w_data & w_mask),
                         w_old[HALF_W-1:0]};
      default:  w_new = w_head_val;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_q_cmd[r_wr_ptr] <= cpu_wr_reg_cmd;
      r_q_idx[r_wr_ptr] <= cpu_wr_reg_idx;
      r_q_val[r_wr_ptr] <= cpu_wr_reg_val;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_upd_valid <= 1'b0;
      r_upd_idx   <= '0;
      r_upd_val   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_upd_valid <= w_commit;
      if (w_commit) begin
        r_upd_idx <= w_head_idx;
        r_upd_val <= w_new;
      end
      // A new error wins over a simultaneous clear.
      if (w_error)      r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_sfr[i] <= '0;
    end else if (w_commit) begin
      r_sfr[w_sfr_addr] <= w_new;
    end
  end

  assign upd_valid = r_upd_valid;
  assign upd_idx   = r_upd_idx;
  assign upd_val   = r_upd_val;
  assign err       = r_err;

`ifdef MMU_SFR_WR_READBACK_EN
  logic [DATA_W-1:0] r_rd_val;
  logic              w_rd_ok;
  logic [SFR_AW-1:0] w_rd_addr;

  assign w_rd_ok   = ({1'b0, rd_idx} < NUM_REGS_LIM);
  assign w_rd_addr = rd_idx[SFR_AW-1:0];

  always_ff @(posedge clock) begin
    if (!reset) r_rd_val <= '0;
    else        r_rd_val <= w_rd_ok ? r_sfr[w_rd_addr] : '0;
  end

  assign rd_val = r_rd_val;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_idx;
  assign rd_val      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmu_sfr_write_unit.sv
`default_nettype none
// Directed testbench for mmu_sfr_write_unit (default parameters).
module tb_mmu_sfr_write_unit;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              cpu_wr_reg_en;
  logic [1:0]        cpu_wr_reg_cmd;
  logic [IDX_W-1:0]  cpu_wr_reg_idx;
  logic [DATA_W-1:0] cpu_wr_reg_val;
  logic              cpu_wr_reg_rdy;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [DATA_W-1:0] upd_val;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_val;
  logic              err;
  logic              err_clr;
  logic              busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  mmu_sfr_write_unit #(
    .DATA_W(32), .NUM_REGS(64), .IDX_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_wr_reg_en(cpu_wr_reg_en), .cpu_wr_reg_cmd(cpu_wr_reg_cmd),
    .cpu_wr_reg_idx(cpu_wr_reg_idx), .cpu_wr_reg_val(cpu_wr_reg_val),
    .cpu_wr_reg_rdy(cpu_wr_reg_rdy),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_val(upd_val),
    .rd_idx(rd_idx), .rd_val(rd_val),
    .err(err), .err_clr(err_clr), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] cmd,
                       input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] val);
    cpu_wr_reg_en  = en;
    cpu_wr_reg_cmd = cmd;
    cpu_wr_reg_idx = idx;
    cpu_wr_reg_val = val;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 2'b00, 8'd2, 32'h0000_0055);
    tick();
    tick();
    vec_cnt++;
    if ({cpu_wr_reg_rdy, upd_valid, err, busy} !== 4'b1000) begin
      err_cnt++;
      $display("FAIL reset_flags: rdy/upd_valid/err/busy=%b required 1000",
               {cpu_wr_reg_rdy, upd_valid, err, busy});
    end
    vec_cnt++;
    if (upd_idx !== 8'd0 || upd_val !== 32'd0 || rd_val !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_data: upd_idx=%0d upd_val=%h rd_val=%h required 0/0/0",
               upd_idx, upd_val, rd_val);
    end
    reset = 1'b1;
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    tick();
    vec_cnt++;
    if (busy !== 1'b0 || upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ignore_req: busy=%b upd_valid=%b required 0/0", busy, upd_valid);
    end
  endtask

  task automatic test_set();
    drive(1'b1, 2'b00, 8'd3, 32'hDEAD_BEEF);
    vec_cnt++;
    if (cpu_wr_reg_rdy !== 1'b1) begin
      err_cnt++;
      $display("FAIL set_rdy: rdy=%b required 1", cpu_wr_reg_rdy);
    end
    tick();
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    vec_cnt++;
    if (busy !== 1'b1 || upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL set_queued: busy=%b upd_valid=%b required 1/0", busy, upd_valid);
    end
    rd_idx = 8'd3;
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b1 || upd_idx !== 8'd3 || upd_val !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL set_commit: valid=%b idx=%0d val=%h busy=%b required 1/3/deadbeef/0",
               upd_valid, upd_idx, upd_val, busy);
    end
    tick();
    vec_cnt++;
`ifdef MMU_SFR_WR_READBACK_EN
    if (rd_val !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL set_readback: rd_val=%h required deadbeef", rd_val);
    end
`else
    if (rd_val !== 32'd0) begin
      err_cnt++;
      $display("FAIL set_readback: rd_val=%h required 0", rd_val);
    end
`endif
    if (upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL set_pulse: upd_valid=%b required 0", upd_valid);
    end
    vec_cnt++;
  endtask

  task automatic test_half_ops();
    logic [1:0]        cmds [3];
    logic [DATA_W-1:0] vals [3];
    logic [DATA_W-1:0] exps [3];
    cmds = '{2'b00, 2'b01, 2'b10};
    vals = '{32'h1234_5678, 32'h00FF_00AB, 32'hFF00_0000};
    exps = '{32'h1234_5678, 32'h1234_56AB, 32'h0034_56AB};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, cmds[i], 8'd5, vals[i]);
      else       drive(1'b0, 2'b00, 8'd0, 32'd0);
      tick();
      if (i > 0) begin
        vec_cnt++;
        if (upd_valid !== 1'b1 || upd_idx !== 8'd5 || upd_val !== exps[i-1]) begin
          err_cnt++;
          $display("FAIL half_op%0d: valid=%b idx=%0d val=%h required 1/5/%h",
                   i - 1, upd_valid, upd_idx, upd_val, exps[i-1]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      if (i < 6) begin
        drive(1'b1, 2'b00, 8'(10 + i), 32'hA000_0000 + 32'(i));
        vec_cnt++;
        if (cpu_wr_reg_rdy !== 1'b1) begin
          err_cnt++;
          $display("FAIL burst_rdy%0d: rdy=%b required 1", i, cpu_wr_reg_rdy);
        end
      end else begin
        drive(1'b0, 2'b00, 8'd0, 32'd0);
      end
      tick();
      if (i > 0) begin
        vec_cnt++;
        if (upd_valid !== 1'b1 || upd_idx !== 8'(9 + i) || upd_val !== 32'hA000_0000 + 32'(i - 1)) begin
          err_cnt++;
          $display("FAIL burst_commit%0d: valid=%b idx=%0d val=%h required 1/%0d/%h",
                   i - 1, upd_valid, upd_idx, upd_val, 9 + i, 32'hA000_0000 + 32'(i - 1));
        end
      end
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL burst_busy: busy=%b required 0", busy);
    end
  endtask

  task automatic test_boundary();
    drive(1'b1, 2'b00, 8'd63, 32'h0000_0063);
    tick();
    drive(1'b1, 2'b00, 8'd64, 32'h0000_0064);
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b1 || upd_idx !== 8'd63 || err !== 1'b0) begin
      err_cnt++;
      $display("FAIL idx63: valid=%b idx=%0d err=%b required 1/63/0", upd_valid, upd_idx, err);
    end
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b0 || err !== 1'b1) begin
      err_cnt++;
      $display("FAIL idx64: valid=%b err=%b required 0/1", upd_valid, err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec_cnt++;
    if (err !== 1'b0) begin
      err_cnt++;
      $display("FAIL idx64_clr: err=%b required 0", err);
    end
  endtask

  task automatic test_error();
    drive(1'b1, 2'b11, 8'd1, 32'h1111_1111);
    tick();
    drive(1'b1, 2'b00, 8'd70, 32'h7070_7070);
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b0 || err !== 1'b1) begin
      err_cnt++;
      $display("FAIL res_cmd: valid=%b err=%b required 0/1", upd_valid, err);
    end
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    rd_idx = 8'd1;
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b0 || err !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL idx70: valid=%b err=%b busy=%b required 0/1/0", upd_valid, err, busy);
    end
    tick();
    vec_cnt++;
    if (rd_val !== 32'd0) begin
      err_cnt++;
      $display("FAIL res_sfr_unchanged: rd_val=%h required 0", rd_val);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec_cnt++;
    if (err !== 1'b0) begin
      err_cnt++;
      $display("FAIL err_clr: err=%b required 0", err);
    end
    drive(1'b1, 2'b11, 8'd0, 32'd0);
    tick();
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vec_cnt++;
    if (err !== 1'b1) begin
      err_cnt++;
      $display("FAIL err_set_vs_clr: err=%b required 1", err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 8'(20 + i), 32'hC000_0000 + 32'(i));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    rd_idx = 8'd20;
    tick();
    reset = 1'b1;
    vec_cnt++;
    if (busy !== 1'b0 || upd_valid !== 1'b0 || upd_idx !== 8'd0 || err !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_state: busy=%b valid=%b idx=%0d err=%b required 0/0/0/0",
               busy, upd_valid, upd_idx, err);
    end
    tick();
    vec_cnt++;
    if (upd_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_discard: valid=%b busy=%b required 0/0", upd_valid, busy);
    end
    vec_cnt++;
    if (rd_val !== 32'd0) begin
      err_cnt++;
      $display("FAIL midreset_sfr20: rd_val=%h required 0", rd_val);
    end
    rd_idx = 8'd5;
    tick();
    vec_cnt++;
    if (rd_val !== 32'd0 || upd_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL midreset_sfr5: rd_val=%h valid=%b required 0/0", rd_val, upd_valid);
    end
  endtask

  initial begin
    reset   = 1'b0;
    err_clr = 1'b0;
    rd_idx  = '0;
    drive(1'b0, 2'b00, 8'd0, 32'd0);
    test_reset();
    test_set();
    test_half_ops();
    test_back_to_back();
    test_boundary();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
